pc_next_unit: RTL and testbench
===============================

# pc_next_unit

Fetch-side consumer of the ID-stage `NPCOp` code. Owns the PC register, computes branch/jump/register targets from ID-stage operands, and steers the next fetch address. Remembers a redirect that arrives while instruction memory is still busy. Raises a one-cycle flush so that IF/ID drops the wrong-path instruction. Sits between the ID-stage PC-source logic and instruction memory, with no branch delay slot.

## Interface
- `RESET_PC`, default 32'h0000_3000: PC value loaded on reset.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ID_NPCOp` in 2: next-PC selector from ID.
  - `NPC_PLUS4`=00
  - `NPC_BRANCH`=01
  - `NPC_JUMP_IMM`=10
  - `NPC_JUMP_REG`=11
- `ID_Valid` in 1: the ID stage holds a real instruction, not a bubble.
- `ID_PC` in 32: PC of the instruction in ID.
- `ID_Imm16` in 16: branch offset in words.
- `ID_Imm26` in 26: jump index.
- `ID_RegData` in 32: forwarded GPR[rs] for JR/JALR.
- `PC_Write` in 1: 0 = hazard stall; freezes PC and pending state and ignores ID.
- `IM_Ready` in 1: instruction fetch at `PC` completes this cycle.
- `PC` out 32: current fetch address.
- `PCPlus4` out 32: `PC`+4, registered into IF/ID.
- `IF_Flush` out 1: the instruction fetched this cycle must be written into IF/ID as a bubble.
- `PC_Misalign` out 1: one-cycle pulse; a JR target had nonzero bits [1:0].

## Operation
- **Redirect request:** `req = ID_Valid & PC_Write & (ID_NPCOp != NPC_PLUS4)`.
- **Targets** (32-bit, wrap modulo 2^32):
  - BRANCH: `ID_PC + 4 + (sext(ID_Imm16) << 2)`.
  - JUMP_IMM: `{(ID_PC+4)[31:28], ID_Imm26, 2'b00}`.
  - JUMP_REG: `{ID_RegData[31:2], 2'b00}`. `PC_Misalign` = `req & op==JUMP_REG & |ID_RegData[1:0]`.
- **FSM states:**
  - `RUN`: no redirect outstanding.
  - `PEND`: a target is held in `pend_pc`.
- **Next-state / next-PC rules, in priority order:**
  1. `rst`: `PC`=`RESET_PC`, state `RUN`, `pend_pc`=0.
  2. `PC_Write`=0: everything holds. `IF_Flush`=0, `PC_Misalign`=0.
  3. `req` & `IM_Ready`: `PC`←new target, state `RUN`, `IF_Flush`=1. A new request overrides any pending target.
  4. `req` & !`IM_Ready`: `pend_pc`←new target, state `PEND`, `PC` holds, `IF_Flush`=0.
  5. `PEND` & `IM_Ready`: `PC`←`pend_pc`, state `RUN`, `IF_Flush`=1 (discards the stale fetch that just completed).
  6. `RUN` & `IM_Ready`: `PC`←`PC`+4.
  7. Otherwise: hold.
- **Outputs:** `IF_Flush` and `PC_Misalign` are combinational from current inputs and state. They are 0 whenever `rst`=1.
- **Invariant:** `PC` is always word-aligned.

## Timing
- Reset values:
  - `PC`=`RESET_PC`, `PCPlus4`=`RESET_PC`+4.
  - `IF_Flush`=0, `PC_Misalign`=0, state `RUN`.
- Redirect latency:
  - The target appears on `PC` the cycle after acceptance (rule 3).
  - When accepted while memory is busy, the target appears the cycle after the first `IM_Ready`=1 (rule 5).
- Penalty: exactly one flushed fetch per taken redirect.
- A `PC_Write`=0 cycle in `PEND` keeps `pend_pc`, even if `IM_Ready`=1. The in-flight fetch is re-presented after the stall.
- `rst` asserted mid-`PEND` discards `pend_pc`. Fetch resumes at `RESET_PC`.
- `PC` wraps 32'hFFFF_FFFC → 32'h0000_0000 with no flag.

## Structure
- Shared `ctrl_encode_def.v` holds:
  - the `NPC_*` encodings;
  - `PC_RESET_DEFAULT`;
  - state encodings `PCU_RUN`=1'b0 and `PCU_PEND`=1'b1.
- One combinational sub-module, `npc_target_calc`: (`ID_NPCOp`, `ID_PC`, `ID_Imm16`, `ID_Imm26`, `ID_RegData`) → (`target`, `misalign`).
- The top level holds the PC register, `pend_pc`, the FSM and the flush logic.

## Test plan
- **Reset and sequential fetch:** `rst` for 2 cycles, then `IM_Ready`=1 with no requests → `PC` = 0x3000, 0x3004, 0x3008; `IF_Flush`=0 throughout.
- **Backward branch:** BRANCH with `ID_PC`=0x3010, `Imm16`=0xFFFC, `IM_Ready`=1 → `IF_Flush`=1 that cycle, next `PC`=0x3004.
- **Jumps:**
  - JUMP_IMM with `ID_PC`=0x3020, `Imm26`=0x0000C40 → `PC`=0x0000_3100.
  - JUMP_REG with `ID_RegData`=0x0000_4006 → `PC`=0x4004 and a 1-cycle `PC_Misalign`.
- **Redirect during busy memory:** BRANCH to 0x3040 with `IM_Ready`=0 for 3 cycles → `PC` holds, state `PEND`. On the first `IM_Ready`=1 → `IF_Flush`=1, next `PC`=0x3040.
- **Hazard stall:** `PC_Write`=0 with `req` present and `IM_Ready`=1 → `PC` unchanged, `IF_Flush`=0. The same request with `PC_Write`=1 the next cycle redirects normally.
- **Reset while pending:** enter `PEND` with target 0x5000, assert `rst` → `PC`=0x3000, state `RUN`. After reset, `IM_Ready`=1 gives 0x3004, not 0x5000.

Source files
------------

// File: rtl/pc_next_unit_pkg.sv
// pc_next_unit_pkg: next-PC opcode, reset PC and fetch-redirect FSM encodings
package pc_next_unit_pkg;
  typedef enum logic [1:0] {
    NPC_PLUS4    = 2'b00,
    NPC_BRANCH   = 2'b01,
    NPC_JUMP_IMM = 2'b10,
    NPC_JUMP_REG = 2'b11
  } npc_op_e;
  typedef enum logic {
    PCU_RUN  = 1'b0,
    PCU_PEND = 1'b1
  } pcu_state_e;
  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;
endpackage

// File: rtl/pc_next_unit_npc_target_calc.sv
// npc_target_calc: branch/jump/register target and JR misalignment from ID operands
module npc_target_calc
  import pc_next_unit_pkg::*;
(
  input  logic [1:0]  ID_NPCOp,
  input  logic [31:0] ID_PC,
  input  logic [15:0] ID_Imm16,
  input  logic [25:0] ID_Imm26,
  input  logic [31:0] ID_RegData,
  output logic [31:0] target,
  output logic        misalign
);
  logic [31:0] pc4;
  always_comb begin
    pc4      = ID_PC + 32'd4;
    target   = ID_NPCOp == NPC_BRANCH   ? pc4 + {{14{ID_Imm16[15]}}, ID_Imm16, 2'b00} :
               ID_NPCOp == NPC_JUMP_IMM ? {pc4[31:28], ID_Imm26, 2'b00} :
                                          {ID_RegData[31:2], 2'b00};
    misalign = (ID_NPCOp == NPC_JUMP_REG) & |ID_RegData[1:0];
  end
endmodule

// File: rtl/pc_next_unit.sv
// pc_next_unit: PC register with redirect steering, busy-memory pending target and IF flush
module pc_next_unit
  import pc_next_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = PC_RESET_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  ID_NPCOp,
  input  logic        ID_Valid,
  input  logic [31:0] ID_PC,
  input  logic [15:0] ID_Imm16,
  input  logic [25:0] ID_Imm26,
  input  logic [31:0] ID_RegData,
  input  logic        PC_Write,
  input  logic        IM_Ready,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        IF_Flush,
  output logic        PC_Misalign
);
  logic [31:0] pc_q, pc_d, pend_pc_q, pend_pc_d, target;
  pcu_state_e  state_q, state_d;
  logic        req, misalign;
  npc_target_calc u_calc (
    .ID_NPCOp  (ID_NPCOp),
    .ID_PC     (ID_PC),
    .ID_Imm16  (ID_Imm16),
    .ID_Imm26  (ID_Imm26),
    .ID_RegData(ID_RegData),
    .target    (target),
    .misalign  (misalign)
  );
  // A new request always wins over a held target; a stall freezes everything.
  always_comb begin
    req         = ID_Valid & PC_Write & (ID_NPCOp != NPC_PLUS4);
    pc_d        = !PC_Write ? pc_q :
                  req       ? (IM_Ready ? target : pc_q) :
                  !IM_Ready ? pc_q :
                  state_q == PCU_PEND ? pend_pc_q : pc_q + 32'd4;
    pend_pc_d   = (req & !IM_Ready) ? target : pend_pc_q;
    state_d     = !PC_Write ? state_q :
                  req       ? (IM_Ready ? PCU_RUN : PCU_PEND) :
                  IM_Ready  ? PCU_RUN : state_q;
    IF_Flush    = !rst & PC_Write & IM_Ready & (req | (state_q == PCU_PEND));
    PC_Misalign = !rst & req & misalign;
    PC          = pc_q;
    PCPlus4     = pc_q + 32'd4;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      pend_pc_q <= '0;
      state_q   <= PCU_RUN;
    end else begin
      pc_q      <= pc_d;
      pend_pc_q <= pend_pc_d;
      state_q   <= state_d;
    end
  end
endmodule

// File: tb/tb_pc_next_unit.sv
// tb_pc_next_unit: table-driven and sequenced checks of the next-PC unit
module tb_pc_next_unit;
  logic        clk = 0, rst = 1;
  logic [1:0]  op = 0;
  logic        v = 0, pw = 1, rdy = 0;
  logic [31:0] idpc = 0, rd = 0;
  logic [15:0] i16 = 0;
  logic [25:0] i26 = 0;
  logic [31:0] pc, pcp4;
  logic        fl, mis;
  int          n_chk = 0, n_fail = 0;

  pc_next_unit dut (
    .clk(clk), .rst(rst), .ID_NPCOp(op), .ID_Valid(v), .ID_PC(idpc),
    .ID_Imm16(i16), .ID_Imm26(i26), .ID_RegData(rd), .PC_Write(pw),
    .IM_Ready(rdy), .PC(pc), .PCPlus4(pcp4), .IF_Flush(fl), .PC_Misalign(mis)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic        v;
    logic [31:0] idpc;
    logic [15:0] i16;
    logic [25:0] i26;
    logic [31:0] rd;
    logic        pw, rdy, fl, mis;
    logic [31:0] npc;
  } vec_t;
  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] o, input logic vv, input logic [31:0] ip,
                       input logic [15:0] a, input logic [25:0] b, input logic [31:0] r,
                       input logic w, input logic y);
    op = o; v = vv; idpc = ip; i16 = a; i26 = b; rd = r; pw = w; rdy = y;
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic do_reset;
    rst = 1;
    drive(0, 0, 0, 0, 0, 0, 1, 1);
    step; step;
    rst = 0;
  endtask

  initial begin
    tbl[0]  = '{2'd0, 1'b1, 32'h0,         16'h0,    26'h0,       32'h0,      1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_3004};
    tbl[1]  = '{2'd0, 1'b1, 32'h0,         16'h0,    26'h0,       32'h0,      1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_3008};
    tbl[2]  = '{2'd1, 1'b1, 32'h3010,      16'hFFFC, 26'h0,       32'h0,      1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_3004};
    tbl[3]  = '{2'd2, 1'b1, 32'h3020,      16'h0,    26'h0000C40, 32'h0,      1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_3100};
    tbl[4]  = '{2'd3, 1'b1, 32'h0,         16'h0,    26'h0,       32'h4006,   1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_4004};
    tbl[5]  = '{2'd0, 1'b1, 32'h0,         16'h0,    26'h0,       32'h4006,   1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_4008};
    tbl[6]  = '{2'd1, 1'b0, 32'h3010,      16'hFFFC, 26'h0,       32'h0,      1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_400C};
    tbl[7]  = '{2'd3, 1'b1, 32'h0,         16'h0,    26'h0,       32'h4001,   1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_400C};
    tbl[8]  = '{2'd3, 1'b1, 32'h0,         16'h0,    26'h0,       32'h4001,   1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_4000};
    tbl[9]  = '{2'd0, 1'b0, 32'h0,         16'h0,    26'h0,       32'h0,      1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_4000};
    tbl[10] = '{2'd2, 1'b1, 32'hF000_0000, 16'h0,    26'h3FFFFFF, 32'h0,      1'b1, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC};
    tbl[11] = '{2'd0, 1'b0, 32'h0,         16'h0,    26'h0,       32'h0,      1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0000};
    tbl[12] = '{2'd1, 1'b1, 32'h0,         16'h0010, 26'h0,       32'h0,      1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0044};

    do_reset;
    chk("reset_pc", pc, 32'h3000);
    chk("reset_pcp4", pcp4, 32'h3004);
    chk("reset_flush", {31'b0, fl}, 32'h0);
    chk("reset_misalign", {31'b0, mis}, 32'h0);

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].op, tbl[i].v, tbl[i].idpc, tbl[i].i16, tbl[i].i26, tbl[i].rd, tbl[i].pw, tbl[i].rdy);
      @(negedge clk);
      chk($sformatf("vec%0d_flush", i), {31'b0, fl}, {31'b0, tbl[i].fl});
      chk($sformatf("vec%0d_misalign", i), {31'b0, mis}, {31'b0, tbl[i].mis});
      step;
      chk($sformatf("vec%0d_pc", i), pc, tbl[i].npc);
      chk($sformatf("vec%0d_pcp4", i), pcp4, tbl[i].npc + 32'd4);
    end

    // redirect accepted while memory busy, resolved on first ready
    do_reset;
    drive(2'd1, 1, 32'h3030, 16'h0003, 0, 0, 1, 0);
    @(negedge clk);
    chk("pend_accept_flush", {31'b0, fl}, 32'h0);
    step;
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    step; step;
    chk("pend_hold_pc", pc, 32'h3000);
    rdy = 1;
    @(negedge clk);
    chk("pend_release_flush", {31'b0, fl}, 32'h1);
    step;
    chk("pend_release_pc", pc, 32'h3040);
    @(negedge clk);
    chk("after_pend_flush", {31'b0, fl}, 32'h0);
    step;
    chk("after_pend_pc", pc, 32'h3044);

    // stall while pending keeps the held target
    do_reset;
    drive(2'd1, 1, 32'h3030, 16'h0003, 0, 0, 1, 0);
    step;
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    chk("pend_stall_flush", {31'b0, fl}, 32'h0);
    step;
    chk("pend_stall_pc", pc, 32'h3000);
    pw = 1;
    @(negedge clk);
    chk("pend_unstall_flush", {31'b0, fl}, 32'h1);
    step;
    chk("pend_unstall_pc", pc, 32'h3040);

    // reset while pending discards the held target
    drive(2'd3, 1, 0, 0, 0, 32'h5000, 1, 0);
    step;
    drive(0, 0, 0, 0, 0, 0, 1, 1);
    rst = 1;
    @(negedge clk);
    chk("rst_pend_flush", {31'b0, fl}, 32'h0);
    step;
    rst = 0;
    chk("rst_pend_pc", pc, 32'h3000);
    @(negedge clk);
    chk("rst_pend_flush2", {31'b0, fl}, 32'h0);
    step;
    chk("rst_pend_next", pc, 32'h3004);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
